// File: rtl/p_mul_sequencer.sv
// Packed SIMD multiply sequencer: runs 2x16-bit or 4x8-bit lane products
// through one shared 17x17 signed multiplier, one lane per cycle, and holds
// the front of the pipeline while it works.
module p_mul_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  alu_control_e,
  input  logic [31:0] src_a_e,
  input  logic [31:0] src_b_e,
  input  logic        flush_e,
  output logic        stall_mul,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [31:0]        op_a, op_b;
  logic               op_is8, op_signed;
  logic [1:0]         lane_cnt;
  logic [63:0]        work, work_next;
  logic               is_mul, accept, last_lane;
  logic [15:0]        a16, b16;
  logic [7:0]         a8, b8;
  logic signed [16:0] lane_a, lane_b;
  logic signed [33:0] product;

  // Decode the four packed-multiply codes; bit 2 selects 8-bit lanes, bit 0 unsigned.
  always_comb begin
    is_mul = 1'b0;
    case (alu_control_e)
      6'b100010, 6'b100011, 6'b100100, 6'b100101: is_mul = 1'b1;
      default:                                    is_mul = 1'b0;
    endcase
  end

  // rst_n gates accept so stall_mul is low the moment reset asserts.
  assign accept    = rst_n & start & ~flush_e & is_mul;
  assign last_lane = op_is8 ? (lane_cnt == 2'd3) : (lane_cnt == 2'd1);

  // Select the current lane and extend it to 17 bits for the shared multiplier.
  always_comb begin
    a16 = op_a[{lane_cnt[0], 4'b0000} +: 16];
    b16 = op_b[{lane_cnt[0], 4'b0000} +: 16];
    a8  = op_a[{lane_cnt, 3'b000} +: 8];
    b8  = op_b[{lane_cnt, 3'b000} +: 8];
    if (op_is8) begin
      lane_a = {{9{op_signed & a8[7]}}, a8};
      lane_b = {{9{op_signed & b8[7]}}, b8};
    end else begin
      lane_a = {op_signed & a16[15], a16};
      lane_b = {op_signed & b16[15], b16};
    end
  end

  assign product = lane_a * lane_b;

  // Drop the truncated lane product into its slot of the working register.
  always_comb begin
    work_next = work;
    if (op_is8)
      work_next[{lane_cnt, 4'b0000} +: 16] = product[15:0];
    else
      work_next[{lane_cnt[0], 5'b00000} +: 32] = product[31:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs; a flush in RUN releases the stall at once.
  always_comb begin
    state_next = state;
    stall_mul  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
          stall_mul  = 1'b1;
        end
      end
      RUN: begin
        if (flush_e) begin
          state_next = IDLE;
        end else begin
          stall_mul = 1'b1;
          if (last_lane) state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, lane counter, working register and published result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      op_is8    <= 1'b0;
      op_signed <= 1'b0;
      lane_cnt  <= '0;
      work      <= '0;
      result    <= '0;
    end else begin
      if (state == IDLE && accept) begin
        op_a      <= src_a_e;
        op_b      <= src_b_e;
        op_is8    <= alu_control_e[2];
        op_signed <= ~alu_control_e[0];
        lane_cnt  <= '0;
        work      <= '0;
      end else if (state == RUN && !flush_e) begin
        work     <= work_next;
        lane_cnt <= lane_cnt + 2'd1;
        if (last_lane) result <= work_next;
      end
    end
  end

endmodule

// File: tb/tb_p_mul_sequencer.sv
// Directed bench for p_mul_sequencer with a result scoreboard queue.
module tb_p_mul_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  alu_control_e;
  logic [31:0] src_a_e, src_b_e;
  logic        flush_e;
  logic        stall_mul, done;
  logic [63:0] result;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_r;

  localparam logic [5:0] SMUL16 = 6'b100010;
  localparam logic [5:0] UMUL16 = 6'b100011;
  localparam logic [5:0] SMUL8  = 6'b100100;
  localparam logic [5:0] UMUL8  = 6'b100101;

  p_mul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_control_e(alu_control_e),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .flush_e(flush_e),
    .stall_mul(stall_mul), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a negedge: drive one op, walk its RUN cycles, check DONE and the cycle after.
  task automatic run_op(input string tag, input logic [5:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expv, input int n,
                        input bit hold_start);
    start = 1'b1; alu_control_e = code; src_a_e = a; src_b_e = b; flush_e = 1'b0;
    sb.push_back(expv);
    #1;
    chk({tag, "_stall_T"}, 64'(stall_mul), 64'd1);
    chk({tag, "_done_T"}, 64'(done), 64'd0);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      src_a_e = $urandom; src_b_e = $urandom;
      #1;
      chk({tag, "_stall_run"}, 64'(stall_mul), 64'd1);
      chk({tag, "_done_run"}, 64'(done), 64'd0);
    end
    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd1);
    chk({tag, "_stall_done"}, 64'(stall_mul), 64'd0);
    if (done) begin
      if (sb.size() > 0) begin
        exp_r = sb.pop_front();
        chk({tag, "_result"}, result, exp_r);
      end else begin
        chk({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
      end
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, "_done_after"}, 64'(done), 64'd0);
    chk({tag, "_stall_after"}, 64'(stall_mul), 64'd0);
    chk({tag, "_result_hold"}, result, expv);
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_control_e = '0; src_a_e = '0; src_b_e = '0; flush_e = 1'b0;
    #1;
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_stall", 64'(stall_mul), 64'd0);
    chk("reset_result", result, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Basic 16-bit and 8-bit ops.
    @(negedge clk);
    run_op("smul16", SMUL16, 32'hFFFF0002, 32'h0003FFFD, 64'hFFFFFFFD_FFFFFFFA, 2, 1'b0);
    @(negedge clk);
    run_op("umul16", UMUL16, 32'hFFFF0002, 32'h0003FFFD, 64'h0002FFFD_0001FFFA, 2, 1'b0);
    @(negedge clk);
    run_op("smul8", SMUL8, 32'h807FFF02, 32'h807F02FF, 64'h40003F01_FFFEFFFE, 4, 1'b0);
    @(negedge clk);
    run_op("umul8", UMUL8, 32'h807FFF02, 32'h807F02FF, 64'h40003F01_01FE01FE, 4, 1'b0);

    // Flush in RUN: no done, result unchanged, stall drops in the flush cycle.
    @(negedge clk);
    start = 1'b1; alu_control_e = SMUL8; src_a_e = 32'h01020304; src_b_e = 32'h05060708;
    #1 chk("flush_stall_T", 64'(stall_mul), 64'd1);
    @(negedge clk);
    start = 1'b0;
    #1 chk("flush_stall_T1", 64'(stall_mul), 64'd1);
    @(negedge clk);
    flush_e = 1'b1;
    #1 chk("flush_stall_T2", 64'(stall_mul), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      flush_e = 1'b0;
      #1;
      chk("flush_no_done", 64'(done), 64'd0);
      chk("flush_no_stall", 64'(stall_mul), 64'd0);
      chk("flush_result_kept", result, 64'h40003F01_01FE01FE);
    end

    // Flush together with a start in IDLE: flush wins.
    @(negedge clk);
    start = 1'b1; alu_control_e = UMUL16; flush_e = 1'b1;
    #1 chk("idle_flush_stall", 64'(stall_mul), 64'd0);
    @(negedge clk);
    start = 1'b0; flush_e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_flush_no_done", 64'(done), 64'd0);
      chk("idle_flush_no_stall", 64'(stall_mul), 64'd0);
      @(negedge clk);
    end

    // Non-mul code with start held: never stalls, never completes.
    start = 1'b1; alu_control_e = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("nonmul_stall", 64'(stall_mul), 64'd0);
      chk("nonmul_done", 64'(done), 64'd0);
      @(negedge clk);
    end
    start = 1'b0;

    // Start held high through DONE: exactly one completion.
    @(negedge clk);
    run_op("held_smul16", SMUL16, 32'h7FFF8000, 32'h80008000, 64'hC0008000_40000000, 2, 1'b1);

    // Reset in the middle of a umul16, then smul16 on the first edge after release.
    @(negedge clk);
    start = 1'b1; alu_control_e = UMUL16; src_a_e = 32'h12345678; src_b_e = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", 64'(stall_mul), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_result", result, 64'd0);
    @(negedge clk);
    #1 chk("rst_hold_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_smul16", SMUL16, 32'h00030004, 32'hFFFE0005, 64'hFFFFFFFA_00000014, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/p_mul_sequencer.md
P_MUL_SEQUENCER -- requirements
Module: p_mul_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock, only clock), rst_n input 1 (asynchronous, active-low reset).
REQ-002 SHALL have start input 1: execute stage holds a valid instruction.
REQ-003 SHALL have alu_control_e input 6: ALU control code of the execute-stage instruction.
REQ-004 SHALL have src_a_e and src_b_e, each input 32: packed operands.
REQ-005 SHALL have flush_e input 1: synchronous kill of the execute-stage instruction.
REQ-006 SHALL have stall_mul output 1: holds the fetch, decode and execute stages.
REQ-007 SHALL have done output 1: result valid, one-cycle pulse.
REQ-008 SHALL have result output 64: packed products.

Function
REQ-009 SHALL recognise exactly four codes: 100010 smul16, 100011 umul16, 100100 smul8, 100101 umul8; all other codes are non-mul.
REQ-010 SHALL implement an FSM with states IDLE, RUN and DONE, using one shared 17x17 signed multiplier.
REQ-011 IDLE with start=1, flush_e=0 and a mul code SHALL latch src_a_e, src_b_e and the op, clear lane_cnt, and go to RUN next cycle.
REQ-012 IDLE with a non-mul code, start=0 or flush_e=1 SHALL stay in IDLE and SHALL NOT stall.
REQ-013 Lane count N SHALL be 2 for 16-bit ops and 4 for 8-bit ops.
REQ-014 Each RUN cycle SHALL multiply lane lane_cnt of the latched operands and write the product into the working register.
  - lane a/b: bits [16i+15:16i] for 16-bit ops, [8i+7:8i] for 8-bit ops.
REQ-015 Signed ops SHALL sign-extend each lane to 17 bits; unsigned ops SHALL zero-extend each lane to 17 bits.
REQ-016 Product placement in the working register:
  - 16-bit ops: 32-bit product to bits [32i+31:32i].
  - 8-bit ops: 16-bit product to bits [16i+15:16i].
  - Products SHALL be truncated to the slot width, with no saturation.
REQ-017 RUN SHALL increment lane_cnt each cycle; at lane_cnt==N-1 it SHALL copy the final working value into result and go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, ignore start, and return to IDLE.
REQ-019 Timing for a start accepted in cycle T:
  - RUN during T+1..T+N.
  - done=1 in cycle T+N+1.
  - result valid from T+N+1 and held until the next completion.
REQ-020 stall_mul SHALL be 1 combinationally in IDLE when REQ-011 holds, 1 throughout RUN, and 0 in DONE and otherwise.
REQ-021 flush_e=1 in RUN SHALL force IDLE next cycle.
  - done SHALL NOT pulse.
  - result SHALL be unchanged.
  - stall_mul SHALL drop in the flush cycle.
REQ-022 Simultaneous flush_e=1 and a mul start in IDLE SHALL be ignored (flush wins).
REQ-023 Operand inputs SHALL be ignored outside the IDLE accept cycle; latched operands SHALL be immune to input changes during RUN.

Reset
REQ-024 rst_n=0 SHALL immediately force the following, regardless of state, including mid-RUN:
  - state IDLE;
  - lane_cnt 0;
  - working register 0;
  - result 0x0000_0000_0000_0000;
  - done 0;
  - stall_mul 0.
REQ-025 After rst_n deasserts, the first start SHALL be accepted at the next rising edge.

Verification
REQ-026 smul16, a=0xFFFF0002, b=0x0003FFFD at T -> stall_mul=1 during T..T+2; done=1 at T+3; result=0xFFFFFFFD_FFFFFFFA.
REQ-027 umul16, same operands -> result=0x0002FFFD_0001FFFA at T+3.
REQ-028 smul8, a=0x807FFF02, b=0x807F02FF -> stall_mul=1 during T..T+4; done=1 at T+5; result=0x40003F01_FFFEFFFE.
  - umul8 with the same operands -> result=0x40003F01_01FE01FE.
REQ-029 smul8 started at T, flush_e=1 at T+2 -> IDLE at T+3; no done pulse; result keeps its prior value; stall_mul=0 at T+2.
REQ-030 rst_n=0 at T+1 of umul16 -> all outputs 0 immediately; after release, a new smul16 completes normally.
REQ-031 start=1 with alu_control_e=000000, and start=1 held high through DONE -> no stall and no extra done for the non-mul code; exactly one done per accepted mul.
